ps2_host_transmitter: RTL

Host-to-device PS/2 transmitter. Sends one command byte at a time (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard over the shared open-drain ps2_clk/ps2_data lines. It complements the PS/2 keyboard receiver on the same lines. The system clock samples the device-generated PS/2 clock; the block never toggles ps2_clk itself, it only inhibits it.

---
 rtl/ps2_host_transmitter.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_host_transmitter.sv
// Host-to-device PS/2 byte transmitter: inhibit, request-to-send, 11-bit frame, ACK check.
// Optional single retry on ack_error/timeout when PS2_TX_RETRY_EN is defined.
module ps2_host_transmitter #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       ps2_clk_drive_low,
    output logic       ps2_data_drive_low,
    output logic       busy,
    output logic       done,
    output logic       ack_error,
    output logic       timeout
);

    localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_DATA,
        S_ACK,
        S_WAIT
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [3:0]    bit_idx_q, bit_idx_d;
    logic [IW-1:0] inh_cnt_q, inh_cnt_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          ok_q, ok_d;
    logic          clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d, clk_prev_q, clk_prev_d;
    logic          dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
    logic          clk_drv_q, clk_drv_d, dat_drv_q, dat_drv_d;
    logic          busy_q, busy_d, tx_ready_q, tx_ready_d;
    logic          done_q, done_d, ack_error_q, ack_error_d, timeout_q, timeout_d;
`ifdef PS2_TX_RETRY_EN
    logic          retry_q, retry_d;
`endif

    logic fall, running, to_hit, fail_ack, finish_ok;

    always_comb begin
        clk_s1_d   = ps2_clk;
        clk_s2_d   = clk_s1_q;
        clk_prev_d = clk_s2_q;
        dat_s1_d   = ps2_data;
        dat_s2_d   = dat_s1_q;
        fall       = clk_prev_q & ~clk_s2_q;

        state_d     = state_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        bit_idx_d   = bit_idx_q;
        inh_cnt_d   = inh_cnt_q;
        to_cnt_d    = to_cnt_q;
        ok_d        = ok_q;
        clk_drv_d   = clk_drv_q;
        dat_drv_d   = dat_drv_q;
        busy_d      = busy_q;
        tx_ready_d  = tx_ready_q;
        done_d      = 1'b0;
        ack_error_d = 1'b0;
        timeout_d   = 1'b0;
`ifdef PS2_TX_RETRY_EN
        retry_d     = retry_q;
`endif
        fail_ack  = 1'b0;
        finish_ok = 1'b0;

        running = (state_q == S_REQ) || (state_q == S_DATA) ||
                  (state_q == S_ACK) || (state_q == S_WAIT);
        to_hit  = running && (to_cnt_q == TO_LAST);
        if (running && !to_hit) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (tx_valid) begin
                    shift_d    = tx_data;
                    parity_d   = ~^tx_data;
                    inh_cnt_d  = '0;
                    clk_drv_d  = 1'b1;
                    dat_drv_d  = 1'b0;
                    busy_d     = 1'b1;
                    tx_ready_d = 1'b0;
                    state_d    = S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
                    retry_d    = 1'b0;
`endif
                end
            end
            S_INHIBIT: begin
                inh_cnt_d = inh_cnt_q + 1'b1;
                if (inh_cnt_q == INH_LAST) begin
                    clk_drv_d = 1'b0;
                    dat_drv_d = 1'b1;
                    bit_idx_d = '0;
                    to_cnt_d  = '0;
                    state_d   = S_REQ;
                end
            end
            S_REQ: begin
                state_d = S_DATA;
            end
            S_DATA: begin
                if (fall) begin
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q < 4'd8) begin
                        dat_drv_d = ~shift_q[bit_idx_q[2:0]];
                    end else if (bit_idx_q == 4'd8) begin
                        dat_drv_d = ~parity_q;
                    end else begin
                        dat_drv_d = 1'b0;
                        state_d   = S_ACK;
                    end
                end
            end
            S_ACK: begin
                if (fall) begin
                    ok_d    = ~dat_s2_q;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (clk_s2_q && dat_s2_q) begin
                    finish_ok = ok_q;
                    fail_ack  = ~ok_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // timeout wins over any fall or ACK outcome in the same cycle
        if (to_hit || fail_ack) begin
            clk_drv_d = 1'b0;
            dat_drv_d = 1'b0;
`ifdef PS2_TX_RETRY_EN
            if (!retry_q) begin
                retry_d   = 1'b1;
                inh_cnt_d = '0;
                clk_drv_d = 1'b1;
                state_d   = S_INHIBIT;
            end else begin
                timeout_d   = to_hit;
                ack_error_d = ~to_hit;
                busy_d      = 1'b0;
                tx_ready_d  = 1'b1;
                state_d     = S_IDLE;
            end
`else
            timeout_d   = to_hit;
            ack_error_d = ~to_hit;
            busy_d      = 1'b0;
            tx_ready_d  = 1'b1;
            state_d     = S_IDLE;
`endif
        end else if (finish_ok) begin
            done_d     = 1'b1;
            clk_drv_d  = 1'b0;
            dat_drv_d  = 1'b0;
            busy_d     = 1'b0;
            tx_ready_d = 1'b1;
            state_d    = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            bit_idx_q   <= '0;
            inh_cnt_q   <= '0;
            to_cnt_q    <= '0;
            ok_q        <= 1'b0;
            clk_s1_q    <= 1'b1;
            clk_s2_q    <= 1'b1;
            clk_prev_q  <= 1'b1;
            dat_s1_q    <= 1'b1;
            dat_s2_q    <= 1'b1;
            clk_drv_q   <= 1'b0;
            dat_drv_q   <= 1'b0;
            busy_q      <= 1'b0;
            tx_ready_q  <= 1'b1;
            done_q      <= 1'b0;
            ack_error_q <= 1'b0;
            timeout_q   <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            retry_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            bit_idx_q   <= bit_idx_d;
            inh_cnt_q   <= inh_cnt_d;
            to_cnt_q    <= to_cnt_d;
            ok_q        <= ok_d;
            clk_s1_q    <= clk_s1_d;
            clk_s2_q    <= clk_s2_d;
            clk_prev_q  <= clk_prev_d;
            dat_s1_q    <= dat_s1_d;
            dat_s2_q    <= dat_s2_d;
            clk_drv_q   <= clk_drv_d;
            dat_drv_q   <= dat_drv_d;
            busy_q      <= busy_d;
            tx_ready_q  <= tx_ready_d;
            done_q      <= done_d;
            ack_error_q <= ack_error_d;
            timeout_q   <= timeout_d;
`ifdef PS2_TX_RETRY_EN
            retry_q     <= retry_d;
`endif
        end
    end

    assign tx_ready           = tx_ready_q;
    assign ps2_clk_drive_low  = clk_drv_q;
    assign ps2_data_drive_low = dat_drv_q;
    assign busy               = busy_q;
    assign done               = done_q;
    assign ack_error          = ack_error_q;
    assign timeout            = timeout_q;

endmodule
